if_stage: RTL and testbench

Instruction-fetch front end of the five-stage LoongArch pipeline. It generates the next PC, issues one read per cycle to the synchronous instruction SRAM, and presents `{inst, pc}` with a valid flag to the decode stage over `IFreg_bus`. It consumes the decode stage's branch bus (`BR_BUS`) to redirect fetch and cancel the wrong-path instruction. The IF/ID pipeline register lives at top level and captures this block's outputs when `ID_allow_in` is high.

---
 rtl/if_stage.sv | 108 ++++++++++
 tb/tb_if_stage.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage : instruction-fetch front end of the five-stage LoongArch pipeline.
//
// Generates the next PC and issues one read per cycle to a synchronous
// instruction SRAM. It presents {inst, pc} with a valid flag to decode and
// follows decode's branch bus to redirect fetch. The IF/ID pipeline register
// sits at top level and captures IFreg_bus/IFreg_valid when ID_allow_in is high.
//
// Ports
//   clk              clock (single domain)
//   reset            synchronous, active-high reset
//   ID_allow_in      decode accepts an instruction this cycle
//   BR_BUS[32:0]     {br_target[31:0], br_taken} from decode
//   IF_ready_go      IF holds a complete instruction
//   IFreg_valid      IFreg_bus carries a live instruction
//   IFreg_bus[63:0]  {inst[31:0], pc[31:0]}
//   inst_sram_en     SRAM read request
//   inst_sram_we     SRAM byte write enables (never written, tied to 0)
//   inst_sram_addr   SRAM read address (the next PC)
//   inst_sram_wdata  SRAM write data (tied to 0)
//   inst_sram_rdata  SRAM read data, valid the cycle after the request
// ---------------------------------------------------------------------------
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ID_allow_in,
  input  logic [32:0] BR_BUS,
  output logic        IF_ready_go,
  output logic        IFreg_valid,
  output logic [63:0] IFreg_bus,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_we,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata
);

  // Branch bus fields
  logic [31:0] br_target;
  logic        br_taken;
  assign {br_target, br_taken} = BR_BUS;

  // IF stage state: the outstanding fetch plus a hold buffer for stalls
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] inst_buf;
  logic        inst_buf_valid;

  // Handshake and pre-IF signals
  logic        br_accept;
  logic        if_allow_in;
  logic        to_if_valid;
  logic [31:0] nextpc;
  logic [31:0] inst;

  // A branch is honoured only when decode fires. With ID_allow_in low its
  // operands may still be unresolved, so br_taken is ignored.
  assign br_accept   = br_taken & ID_allow_in;

  assign IF_ready_go = if_valid;
  // br_accept implies ID_allow_in, and if_valid is either low or ready_go is
  // high, so a branch always finds IF willing to take the redirected fetch.
  assign if_allow_in = ~if_valid | (IF_ready_go & ID_allow_in);

  assign to_if_valid = ~reset;
  assign nextpc      = br_accept ? br_target : (if_pc + 32'd4);

  assign inst_sram_en    = to_if_valid & if_allow_in;
  assign inst_sram_addr  = nextpc;
  assign inst_sram_we    = 4'b0000;
  assign inst_sram_wdata = 32'h0000_0000;

  // SRAM data is only valid for one cycle after the request. During a stall
  // the buffer holds the instruction so IFreg_bus stays constant.
  assign inst        = inst_buf_valid ? inst_buf : inst_sram_rdata;
  assign IFreg_bus   = {inst, if_pc};
  // On a taken branch the instruction in IF is the fall-through, so it is
  // cancelled here. The IF/ID register then captures a bubble.
  assign IFreg_valid = if_valid & ~br_accept;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, matching real flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      if_valid       <= 1'b0;
      if_pc          <= RESET_PC - 32'd4;   // so the first nextpc is RESET_PC
      inst_buf_valid <= 1'b0;
    end else if (if_allow_in) begin
      if_valid       <= to_if_valid;
      if_pc          <= nextpc;
      inst_buf_valid <= 1'b0;
    end else if (if_valid && !inst_buf_valid) begin
      // First stalled cycle: the SRAM output is still the held instruction.
      inst_buf_valid <= 1'b1;
    end
  end

  // NOTE: the buffer data has no reset. It is only read while inst_buf_valid
  // is set, and that flag is reset, so clearing the data would add nothing.
  always_ff @(posedge clk) begin
    if (!reset && !if_allow_in && if_valid && !inst_buf_valid) begin
      inst_buf <= inst_sram_rdata;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage : self-checking bench for if_stage.
// A synchronous SRAM model returns mem_word(addr) one cycle after a request.
// Its output can be overridden to a junk value to prove that stalls read
// from the hold buffer. A behavioural model tracks which instruction IF holds
// and is compared against the DUT every cycle. Directed literal checks pin
// the model at key points.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_if_stage;

  localparam logic [31:0] RESET_PC = 32'h1c000000;

  logic        clk = 1'b0;
  logic        reset;
  logic        ID_allow_in;
  logic [32:0] BR_BUS;
  logic        IF_ready_go;
  logic        IFreg_valid;
  logic [63:0] IFreg_bus;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  if_stage #(.RESET_PC(RESET_PC)) dut (
    .clk             (clk),
    .reset           (reset),
    .ID_allow_in     (ID_allow_in),
    .BR_BUS          (BR_BUS),
    .IF_ready_go     (IF_ready_go),
    .IFreg_valid     (IFreg_valid),
    .IFreg_bus       (IFreg_bus),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_we    (inst_sram_we),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata)
  );

  always #5 clk = ~clk;

  // Memory image: each word is its address XORed with a fixed pattern.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5a5a_0000;
  endfunction

  // Synchronous instruction SRAM
  logic [31:0] sram_q;
  logic        rdata_junk = 1'b0;
  always @(posedge clk) if (inst_sram_en) sram_q <= mem_word(inst_sram_addr);
  assign inst_sram_rdata = rdata_junk ? 32'hdeadbeef : sram_q;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the instruction held by IF, described by program order.
  // IF hands its instruction off whenever it is empty or decode accepts. The
  // next one held is the branch target if decode's branch fired this cycle,
  // otherwise the sequential successor. Whatever IF holds, its word is mem[pc].
  logic        m_valid;
  logic [31:0] m_pc;
  logic        chk_en = 1'b0;
  wire         in_taken  = BR_BUS[0];
  wire  [31:0] in_target = BR_BUS[32:1];

  function automatic logic [31:0] successor(input logic [31:0] pc, input logic fired,
                                            input logic [31:0] target);
    return fired ? target : pc + 32'd4;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_valid <= 1'b0;
      m_pc    <= RESET_PC - 32'd4;
    end else if (!m_valid || ID_allow_in) begin
      m_valid <= 1'b1;
      m_pc    <= successor(m_pc, in_taken && ID_allow_in, in_target);
    end
  end

  // Per-cycle compare against the model, sampled mid-cycle
  always @(negedge clk) begin
    if (chk_en) begin
      logic fired;
      fired = in_taken & ID_allow_in;
      check("ready_go",    {63'd0, IF_ready_go},  {63'd0, m_valid});
      check("ifreg_valid", {63'd0, IFreg_valid},  {63'd0, m_valid & ~fired});
      check("sram_en",     {63'd0, inst_sram_en}, {63'd0, ~reset & (~m_valid | ID_allow_in)});
      check("sram_addr",   {32'd0, inst_sram_addr}, {32'd0, successor(m_pc, fired, in_target)});
      check("bus_pc",      {32'd0, IFreg_bus[31:0]}, {32'd0, m_pc});
      if (m_valid) check("bus_inst", {32'd0, IFreg_bus[63:32]}, {32'd0, mem_word(m_pc)});
      check("sram_we",     {60'd0, inst_sram_we}, 64'd0);
      check("sram_wdata",  {32'd0, inst_sram_wdata}, 64'd0);
    end
  end

  task automatic next();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Directed literal check of the visible interface
  task automatic pin(input string name, input logic v, input logic en,
                     input logic [31:0] pc, input logic [31:0] addr);
    check({name, ".valid"}, {63'd0, IFreg_valid},  {63'd0, v});
    check({name, ".en"},    {63'd0, inst_sram_en}, {63'd0, en});
    check({name, ".pc"},    {32'd0, IFreg_bus[31:0]}, {32'd0, pc});
    check({name, ".addr"},  {32'd0, inst_sram_addr}, {32'd0, addr});
  endtask

  task automatic pin_inst(input string name, input logic [31:0] w);
    check({name, ".inst"}, {32'd0, IFreg_bus[63:32]}, {32'd0, w});
  endtask

  // One reset cycle, then reset released. Returns in the middle of c0.
  task automatic do_reset();
    next(); reset = 1'b1; mid();
    next(); reset = 1'b0; ID_allow_in = 1'b1; BR_BUS = '0; rdata_junk = 1'b0; mid();
  endtask

  initial begin
    reset = 1'b1; ID_allow_in = 1'b1; BR_BUS = '0;

    // Reset state
    next(); chk_en = 1'b1; mid();
    pin("reset", 1'b0, 1'b0, 32'h1bfffffc, 32'h1c000000);
    check("reset.ready_go", {63'd0, IF_ready_go}, 64'd0);

    // Reset release: c0 requests RESET_PC, c1 delivers it
    next(); reset = 1'b0; mid();
    pin("c0", 1'b0, 1'b1, 32'h1bfffffc, 32'h1c000000);
    next(); mid();
    pin("c1", 1'b1, 1'b1, 32'h1c000000, 32'h1c000004);
    pin_inst("c1", 32'h465a0000);

    // Straight-line stream: no bubbles for 8 cycles
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin next(); mid(); end
      check("stream.valid", {63'd0, IFreg_valid}, 64'd1);
      check("stream.pc", {32'd0, IFreg_bus[31:0]}, {32'd0, 32'h1c000000 + 32'(4 * i)});
    end

    // Stall at 0x1c000008 for 3 cycles, junk rdata from the second cycle on.
    // A taken branch in the last stall cycle must be ignored.
    do_reset();
    next(); mid();                      // pc 00
    next(); mid();                      // pc 04
    next(); ID_allow_in = 1'b0; mid();  // pc 08, stall 1
    pin("stall1", 1'b1, 1'b0, 32'h1c000008, 32'h1c00000c);
    pin_inst("stall1", 32'h465a0008);
    next(); rdata_junk = 1'b1; mid();
    pin("stall2", 1'b1, 1'b0, 32'h1c000008, 32'h1c00000c);
    pin_inst("stall2", 32'h465a0008);
    next(); BR_BUS = {32'h1c000100, 1'b1}; mid();
    pin("ign_br", 1'b1, 1'b0, 32'h1c000008, 32'h1c00000c);
    pin_inst("ign_br", 32'h465a0008);
    next(); BR_BUS = '0; ID_allow_in = 1'b1; rdata_junk = 1'b0; mid();
    pin("release", 1'b1, 1'b1, 32'h1c000008, 32'h1c00000c);
    next(); mid();
    pin("after_stall", 1'b1, 1'b1, 32'h1c00000c, 32'h1c000010);
    pin_inst("after_stall", 32'h465a000c);

    // Taken branch while IF holds 0x1c000010
    next(); BR_BUS = {32'h1c000100, 1'b1}; mid();
    pin("branch", 1'b0, 1'b1, 32'h1c000010, 32'h1c000100);
    next(); BR_BUS = '0; mid();
    pin("target", 1'b1, 1'b1, 32'h1c000100, 32'h1c000104);
    pin_inst("target", 32'h465a0100);
    next(); mid();
    pin("target+4", 1'b1, 1'b1, 32'h1c000104, 32'h1c000108);

    // Reset during a stall at 0x1c000014
    do_reset();
    for (int i = 0; i < 5; i++) begin next(); mid(); end   // pc 00..10
    next(); ID_allow_in = 1'b0; mid();
    pin("rst_stall1", 1'b1, 1'b0, 32'h1c000014, 32'h1c000018);
    next(); rdata_junk = 1'b1; mid();
    pin_inst("rst_stall2", 32'h465a0014);
    next(); reset = 1'b1; mid();
    pin("rst_cycle", 1'b1, 1'b0, 32'h1c000014, 32'h1c000018);
    next(); reset = 1'b0; ID_allow_in = 1'b1; rdata_junk = 1'b0; mid();
    pin("rst_after", 1'b0, 1'b1, 32'h1bfffffc, 32'h1c000000);
    check("rst_after.ready_go", {63'd0, IF_ready_go}, 64'd0);
    next(); mid();
    pin("restart", 1'b1, 1'b1, 32'h1c000000, 32'h1c000004);
    pin_inst("restart", 32'h465a0000);
    next(); mid();
    next(); mid();

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
